// File: rtl/serial_pkg.sv
// Shared constants for the serial transmitter and its matching receiver.
package serial_pkg;

  // FSM state encoding
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Default word length shared by the transmitter and the receiver
  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_tx_piso_if.sv
// Load handshake and framed serial output bundle for serial_tx_piso.
interface serial_tx_piso_if
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_b;
  logic             sout_valid;
  logic             sout_last;

  // Requester side: supplies words and observes the serial line
  modport master (
    output din, load_valid,
    input  load_ready, sout, sout_b, sout_valid, sout_last
  );

  // Transmitter side
  modport slave (
    input  din, load_valid,
    output load_ready, sout, sout_b, sout_valid, sout_last
  );
endinterface

// File: rtl/bit_counter_down.sv
// Loadable down-counter that saturates at zero.
module bit_counter_down #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_value,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  // Load takes priority; decrement stops at zero so the count never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == '0);
endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out transmitter with valid/ready load and framed output.
// Bits launch on the rising edge so the receiver can sample on the falling edge.
module serial_tx_piso
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst,
  serial_tx_piso_if.slave bus
);
  localparam int unsigned     CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic             r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;
  logic             w_shifting;
  logic             w_ready;
  logic             w_accept;
  logic             w_cnt_en;
  logic             w_out_bit;

  assign w_shifting = (r_state == ST_SHIFT);
  // Ready in the last-bit cycle lets the next word follow with no gap
  assign w_ready    = (r_state == ST_IDLE) || (w_shifting && w_cnt_zero);
  assign w_accept   = bus.load_valid && w_ready;
  assign w_cnt_en   = w_shifting && !w_accept && (w_cnt != '0);

  bit_counter_down #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_en      (w_cnt_en),
    .i_load_val(CNT_MAX),
    .o_value   (w_cnt),
    .o_zero    (w_cnt_zero)
  );

  // Next shift-register contents: load on accept, else zero-filled shift toward the output end
  always_comb begin
    w_shift_next = r_shift;
    if (w_accept) begin
      w_shift_next = bus.din;
    end else if (w_shifting) begin
      if (MSB_FIRST) begin
        w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
      end else begin
        w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
      end
    end
  end

  // Shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
    end else begin
      r_shift <= w_shift_next;
    end
  end

  // FSM: IDLE -> SHIFT on accept, SHIFT -> IDLE after the last bit with no new word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
    end else if (w_shifting && w_cnt_zero) begin
      r_state <= ST_IDLE;
    end
  end

  assign w_out_bit      = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign bus.sout       = w_shifting & w_out_bit;
  assign bus.sout_b     = ~bus.sout;
  assign bus.sout_valid = w_shifting;
  assign bus.sout_last  = w_shifting & w_cnt_zero;
  assign bus.load_ready = w_ready;
endmodule

// File: tb/tb_serial_tx_piso.sv
// Directed bench for serial_tx_piso: inputs change and outputs are checked on the falling edge.
module tb_serial_tx_piso;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  serial_tx_piso_if #(.WIDTH(8)) bus_m ();
  serial_tx_piso_if #(.WIDTH(8)) bus_l ();

  serial_tx_piso #(
    .WIDTH    (8),
    .MSB_FIRST(1'b1)
  ) u_dut_msb (
    .clk(clk),
    .rst(rst),
    .bus(bus_m)
  );

  serial_tx_piso #(
    .WIDTH    (8),
    .MSB_FIRST(1'b0)
  ) u_dut_lsb (
    .clk(clk),
    .rst(rst),
    .bus(bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks every output of the MSB-first instance against expected values
  task automatic chk_m(input string tag, input logic e_sout, input logic e_valid,
                       input logic e_last, input logic e_ready);
    chk({tag, ".sout"},   bus_m.sout,       e_sout);
    chk({tag, ".sout_b"}, bus_m.sout_b,     ~e_sout);
    chk({tag, ".valid"},  bus_m.sout_valid, e_valid);
    chk({tag, ".last"},   bus_m.sout_last,  e_last);
    chk({tag, ".ready"},  bus_m.load_ready, e_ready);
  endtask

  initial begin
    logic [7:0]  w_a5;
    logic [7:0]  w_81;
    logic [7:0]  w_01;
    logic [15:0] w_stream;
    w_a5     = 8'b1010_0101;
    w_81     = 8'b1000_0001;
    w_01     = 8'b0000_0001;
    w_stream = 16'b1010_0101_0011_1100;
    n_checks = 0;
    n_errors = 0;

    // Reset held low with a pending request that must be ignored
    rst              = 1'b0;
    bus_m.din        = 8'hFF;
    bus_m.load_valid = 1'b1;
    bus_l.din        = 8'hFF;
    bus_l.load_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk_m("rst_low", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_low.lsb_valid", bus_l.sout_valid, 1'b0);
    bus_m.load_valid = 1'b0;
    bus_l.load_valid = 1'b0;
    rst              = 1'b1;
    @(negedge clk);
    chk_m("rst_rel", 1'b0, 1'b0, 1'b0, 1'b1);

    // Single word 0xA5, MSB first
    bus_m.din        = 8'hA5;
    bus_m.load_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_m($sformatf("single[%0d]", k), w_a5[7-k], 1'b1, k == 7, k == 7);
      bus_m.load_valid = 1'b0;
    end
    @(negedge clk);
    chk_m("single_end", 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back 0xA5 then 0x3C with load_valid held high
    bus_m.din        = 8'hA5;
    bus_m.load_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk_m($sformatf("b2b[%0d]", k), w_stream[15-k], 1'b1, (k == 7) || (k == 15),
            (k == 7) || (k == 15));
      if (k == 0) bus_m.din = 8'h3C;
      if (k == 15) bus_m.load_valid = 1'b0;
    end
    @(negedge clk);
    chk_m("b2b_end", 1'b0, 1'b0, 1'b0, 1'b1);

    // Busy: din changes and load_valid pulses at cnt=5 must have no effect
    bus_m.din        = 8'hA5;
    bus_m.load_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_m($sformatf("busy[%0d]", k), w_a5[7-k], 1'b1, k == 7, k == 7);
      bus_m.load_valid = (k == 2);
      if (k == 2) bus_m.din = 8'h00;
    end
    @(negedge clk);
    chk_m("busy_end", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_m("busy_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Bit order: LSB-first instance sends 0x01 as 1 then seven 0s
    bus_l.din        = 8'h01;
    bus_l.load_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("lsb[%0d].sout", k),  bus_l.sout,       w_01[k]);
      chk($sformatf("lsb[%0d].valid", k), bus_l.sout_valid, 1'b1);
      chk($sformatf("lsb[%0d].last", k),  bus_l.sout_last,  k == 7);
      bus_l.load_valid = 1'b0;
    end
    @(negedge clk);
    chk("lsb_end.valid", bus_l.sout_valid, 1'b0);

    // Abort: asynchronous reset mid-cycle after the third bit of 0xA5
    bus_m.din        = 8'hA5;
    bus_m.load_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_m($sformatf("abort[%0d]", k), w_a5[7-k], 1'b1, 1'b0, 1'b0);
      bus_m.load_valid = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    chk_m("abort_now", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk_m("abort_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_m("abort_rel", 1'b0, 1'b0, 1'b0, 1'b1);

    // Clean frame 0x81 after the abort
    bus_m.din        = 8'h81;
    bus_m.load_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_m($sformatf("post[%0d]", k), w_81[7-k], 1'b1, k == 7, k == 7);
      bus_m.load_valid = 1'b0;
    end
    @(negedge clk);
    chk_m("post_end", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_tx_piso.md
# serial_tx_piso

Parallel-in serial-out transmitter that accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock on a framed serial line. It is the sending end for the negative-edge-sampled flip-flop and shift-register receivers in the sequential logic library. It launches bits on the rising edge so that each bit is stable at the receiver's falling-edge sample point. It supports back-to-back words with no idle gap.

## Interface
- WIDTH, 8, word length in bits; legal range is WIDTH ≥ 2.
- MSB_FIRST, 1, bit order: 1 sends din[WIDTH-1] first, 0 sends din[0] first.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word; sampled only when a load is accepted.
- load_valid  input  1  requester has a word on din.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_b  output  1  always the complement of sout.
- sout_valid  output  1  high while sout carries a frame bit.
- sout_last  output  1  high while the final bit of a frame is on sout.

## Operation
- State machine has two states: IDLE and SHIFT. Reset places it in IDLE.
- Accept condition: load_valid && load_ready, sampled at a rising edge.
- load_ready is combinational and defined as (state==IDLE) || (state==SHIFT && cnt==0).
- On accept:
  - din is captured into the shift register.
  - cnt is set to WIDTH-1.
  - State goes to SHIFT.
- In SHIFT, on each rising edge without an accept:
  - The register shifts toward the output end (left if MSB_FIRST, right otherwise), zero-filled.
  - cnt decrements.
- In SHIFT with cnt==0:
  - With an accept at that edge, the new word is loaded and state stays SHIFT. There is no gap cycle.
  - Without an accept, state goes to IDLE.
- sout is the output-end bit of the shift register while in SHIFT, and 0 in IDLE.
- sout_valid = (state==SHIFT).
- sout_last = (state==SHIFT && cnt==0).
- While busy (SHIFT, cnt≠0), load_valid is ignored and din changes have no effect.
- cnt width is $clog2(WIDTH). It never wraps below 0.
- Values while rst is low, and immediately after it deasserts:
  - state=IDLE, shift register=0, cnt=0.
  - sout=0, sout_b=1, sout_valid=0, sout_last=0, load_ready=1.
  - Any load_valid seen while rst is low is ignored.
- Reset mid-frame: outputs go to their reset values asynchronously. The frame is aborted and sout_last is never asserted for it. The first edge after release behaves as from IDLE.

## Timing
- Latency: word accepted at edge N puts its first bit on sout after edge N (one-edge latency).
- Bit k (k = 0 being the first bit sent) is on sout from edge N+k to edge N+k+1, for k = 0..WIDTH-1.
- sout_last is high during cycle N+WIDTH-1.
- Throughput: one word per WIDTH cycles when load_valid is held high. sout_valid then stays continuously high across words.
- Without a new accept at edge N+WIDTH, the block is in IDLE with sout_valid=0 and sout=0 after that edge.
- All outputs except load_ready are driven from registers. Receivers sample on the falling edge, with half a cycle of setup.

## Structure
- Shared package serial_pkg holds:
  - state encoding constants ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - the default WIDTH constant, for reuse by the matching receiver.
- One sub-module, bit_counter_down: a loadable down-counter with load, en, value and zero outputs, and asynchronous active-low reset. The shift register and FSM stay in serial_tx_piso.

## Test plan
- Reset: assert rst=0 with load_valid=1 and din=8'hFF -> sout=0, sout_b=1, sout_valid=0, load_ready=1, and no frame starts until rst=1.
- Single word: WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted at edge N -> sout reads 1,0,1,0,0,1,0,1 over 8 cycles. sout_valid is high for exactly those 8 cycles, sout_last is high only on the 8th, then the block returns to IDLE.
- Back-to-back: 8'hA5 then 8'h3C, with load_valid held high -> 16 contiguous valid bits 10100101 00111100. load_ready is high only in the IDLE cycle and the two last-bit cycles. sout_last pulses twice.
- Busy: during the frame of 8'hA5, change din to 8'h00 and pulse load_valid at cnt=5 -> the serial data is unchanged and no second frame starts.
- Bit order: MSB_FIRST=0, din=8'h01 -> sout reads 1 then seven 0s, with sout_last on the 8th bit.
- Abort: drive rst low asynchronously, mid-cycle, after the 3rd bit of 8'hA5 -> outputs go to their reset values immediately, with no sout_last. After release, a new word 8'h81 is sent cleanly as 1,0,0,0,0,0,0,1.
